cic_comp_fir: RTL and testbench
===============================

# cic_comp_fir

Time-multiplexed compensation FIR placed directly downstream of the CIC decimator. It consumes the decimated CIC output stream and flattens the CIC passband droop with a programmable symmetric-agnostic FIR of NUM_TAPS coefficients. The decimated rate is low, so a single multiplier-accumulator is enough. Output feeds the next decimation/packing stage as a valid-only stream.

## Interface
- INP_DW, 32: input sample width, equal to CIC OUT_DW; signed
- OUT_DW, 32: output sample width; signed
- COEF_DW, 18: coefficient width, signed Q2.(COEF_DW-2); unity = 2^(COEF_DW-2)
- NUM_TAPS, 21: number of taps, 2..64
- ACC_DW, derived: INP_DW+COEF_DW+$clog2(NUM_TAPS); not overridable
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- s_axis_in_tdata  in  INP_DW  sample from CIC
- s_axis_in_tvalid  in  1  sample strobe
- s_axis_in_tready  out  1  high only in IDLE; informational, upstream has no backpressure
- s_axis_coef_tdata  in  COEF_DW  coefficient write data
- s_axis_coef_tvalid  in  1  coefficient write strobe
- s_axis_coef_tlast  in  1  last coefficient of a set; wraps pointer
- s_axis_coef_tready  out  1  high only in IDLE
- m_axis_out_tdata  out  OUT_DW  filtered sample, held between strobes
- m_axis_out_tvalid  out  1  one-cycle strobe
- overflow  out  1  sticky: an input sample was dropped

## Operation
- Delay line: circular buffer x[0..NUM_TAPS-1] with wr_ptr. Coefficient registers c[0..NUM_TAPS-1] with coef_ptr.
- FSM states: IDLE, MAC, DRAIN, OUT.
- IDLE + s_axis_in_tvalid: write the sample at wr_ptr. Latch base = wr_ptr. Advance wr_ptr, wrapping NUM_TAPS-1 to 0. Clear acc and tap. Go to MAC.
- MAC, tap = 0..NUM_TAPS-1, one per cycle: prod_reg <= c[tap]*x[(base-tap) mod NUM_TAPS]. From the second MAC cycle on, acc += prod_reg. After tap NUM_TAPS-1, go to DRAIN.
- DRAIN: add the final product into acc. Go to OUT.
- OUT: m_axis_out_tdata <= sat(round(acc)). m_axis_out_tvalid = 1 for this one cycle only. Go to IDLE.
- round: add 2^(COEF_DW-3) to acc, then arithmetic shift right by COEF_DW-2 (round half up).
- sat: clamp to [-2^(OUT_DW-1), 2^(OUT_DW-1)-1].
- Full-width products and accumulation. No intermediate truncation.
- Input while not IDLE: the sample is dropped, overflow <= 1, and the state machine is unaffected. overflow clears only on reset.
- Coefficient write:
  - Accepted only when s_axis_coef_tvalid && s_axis_coef_tready. It writes c[coef_ptr].
  - coef_ptr increments, wrapping NUM_TAPS-1 to 0. If tlast is high, coef_ptr goes to 0.
  - Writes while busy are ignored (not queued).
  - A simultaneous coefficient write and input sample in IDLE: the coefficient write occurs first; the MAC uses the new value.

## Timing
- Input sampled at edge E. m_axis_out_tvalid is high in the cycle after edge E+NUM_TAPS+2, giving a latency of NUM_TAPS+3 cycles.
- Minimum input spacing for loss-free operation: NUM_TAPS+3 cycles. The CIC decimation ratio must guarantee this.
- s_axis_in_tready and s_axis_coef_tready deassert in the cycle after acceptance and reassert in the cycle after OUT.
- Reset values:
  - Outputs: m_axis_out_tdata=0, m_axis_out_tvalid=0, overflow=0, both treadys=1.
  - State IDLE; wr_ptr=0, coef_ptr=0; x[] all 0.
  - c[0]=2^(COEF_DW-2), other c[] 0, i.e. unity pass-through.
- Reset asserted mid-MAC: everything returns to reset values immediately; no output strobe is produced.

## Structure
- Shared package cic_pkg holds:
  - the state enum typedef cic_comp_state_t;
  - the function acc_width(INP_DW, COEF_DW, NUM_TAPS).
- Sub-module round_sat: a combinational acc-to-OUT_DW rounding and saturation block, reused later by other output stages.
- Everything else lives in cic_comp_fir.

## Test plan
All values use COEF_DW=18 (unity 65536) and NUM_TAPS=5 unless noted.
- Reset defaults: input 1000 → output 1000, tvalid high exactly one cycle, 8 cycles after input.
- Load five coefficients of 65536 with tlast on the 5th. Impulse 100 then zeros, spaced 10 cycles → outputs 100,100,100,100,100,0. Step of 100 → 100,200,300,400,500,500.
- Saturation, OUT_DW=16, INP_DW=16, c[0]=131071:
  - input 30000 → 32767;
  - input -32768 → -32768.
- Rounding, c[0]=1:
  - input 32768 → 1 (+0.5 rounds up);
  - input -32768 → 0 (-0.5 rounds up);
  - input 16384 → 0 (+0.25).
- Overflow: second input 3 cycles after the first → second input dropped, overflow=1, first output correct, next output only for the next legal input. Coefficient write during MAC → ignored.
- Reset mid-MAC (cycle 3): no tvalid. After reset, input 7 → output 7 (impulse coefficients restored, delay line cleared).

Source files
------------

// File: rtl/cic_pkg.sv
// Shared types and helpers for the CIC decimation chain output stages.
package cic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_DRAIN,
    ST_OUT
  } cic_comp_state_t;

  // Accumulator width that holds NUM_TAPS full-width products without loss.
  function automatic int unsigned acc_width(input int unsigned inp_dw,
                                            input int unsigned coef_dw,
                                            input int unsigned num_taps);
    return inp_dw + coef_dw + int'($clog2(num_taps));
  endfunction

endpackage

// File: rtl/round_sat.sv
// Round-half-up arithmetic right shift followed by saturation to OUT_DW.
module round_sat #(
  parameter int unsigned IN_DW  = 53,
  parameter int unsigned OUT_DW = 32,
  parameter int unsigned SHIFT  = 16
) (
  input  logic signed [IN_DW-1:0]  acc,
  output logic signed [OUT_DW-1:0] dout_c
);

  // One guard bit so adding the rounding constant can never wrap.
  localparam int unsigned EW = IN_DW + 1;

  localparam logic signed [EW-1:0] HALF =
    {{(EW-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
  localparam logic signed [EW-1:0] MAX_V =
    {{(EW-OUT_DW+1){1'b0}}, {(OUT_DW-1){1'b1}}};
  localparam logic signed [EW-1:0] MIN_V =
    {{(EW-OUT_DW+1){1'b1}}, {(OUT_DW-1){1'b0}}};

  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] rnd;

  assign ext = EW'(acc);
  assign rnd = (ext + HALF) >>> SHIFT;

  always_comb begin
    dout_c = OUT_DW'(rnd);
    if (rnd > MAX_V) begin
      dout_c = OUT_DW'(MAX_V);
    end else if (rnd < MIN_V) begin
      dout_c = OUT_DW'(MIN_V);
    end
  end

endmodule

// File: rtl/cic_comp_fir.sv
// CIC droop compensation FIR: circular delay line, one shared MAC,
// rounded and saturated valid-only output stream.
module cic_comp_fir
  import cic_pkg::*;
#(
  parameter int unsigned INP_DW   = 32,
  parameter int unsigned OUT_DW   = 32,
  parameter int unsigned COEF_DW  = 18,
  parameter int unsigned NUM_TAPS = 21
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic signed [INP_DW-1:0]  s_axis_in_tdata,
  input  logic                      s_axis_in_tvalid,
  output logic                      s_axis_in_tready,
  input  logic signed [COEF_DW-1:0] s_axis_coef_tdata,
  input  logic                      s_axis_coef_tvalid,
  input  logic                      s_axis_coef_tlast,
  output logic                      s_axis_coef_tready,
  output logic signed [OUT_DW-1:0]  m_axis_out_tdata,
  output logic                      m_axis_out_tvalid,
  output logic                      overflow
);

  localparam int unsigned ACC_DW  = acc_width(INP_DW, COEF_DW, NUM_TAPS);
  localparam int unsigned PROD_DW = INP_DW + COEF_DW;
  localparam int unsigned PTR_W   = $clog2(NUM_TAPS);

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_TAPS - 1);
  localparam logic signed [COEF_DW-1:0] UNITY = {2'b01, {(COEF_DW-2){1'b0}}};

  cic_comp_state_t state_q;
  cic_comp_state_t state_d;

  logic signed [INP_DW-1:0]  x_mem [NUM_TAPS];
  logic signed [COEF_DW-1:0] c_mem [NUM_TAPS];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] coef_ptr;
  logic [PTR_W-1:0] base;
  logic [PTR_W-1:0] tap;
  logic [PTR_W-1:0] rd_idx;

  logic signed [PROD_DW-1:0] prod_reg;
  logic signed [ACC_DW-1:0]  acc;
  logic signed [OUT_DW-1:0]  rs_c;

  logic in_fire;
  logic coef_fire;

  assign in_fire   = s_axis_in_tvalid && (state_q == ST_IDLE);
  assign coef_fire = s_axis_coef_tvalid && s_axis_coef_tready;

  // Newest sample sits at base; older taps walk backwards around the ring.
  assign rd_idx = (base >= tap) ? PTR_W'(base - tap)
                                : PTR_W'(int'(base) + int'(NUM_TAPS) - int'(tap));

  round_sat #(
    .IN_DW (ACC_DW),
    .OUT_DW(OUT_DW),
    .SHIFT (COEF_DW - 2)
  ) u_round_sat (
    .acc   (acc),
    .dout_c(rs_c)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (s_axis_in_tvalid) state_d = ST_MAC;
      ST_MAC:   if (tap == LAST_IDX) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_OUT;
      ST_OUT:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath, coefficient bank and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_axis_in_tready   <= 1'b1;
      s_axis_coef_tready <= 1'b1;
      m_axis_out_tdata   <= '0;
      m_axis_out_tvalid  <= 1'b0;
      overflow           <= 1'b0;
      wr_ptr             <= '0;
      coef_ptr           <= '0;
      base               <= '0;
      tap                <= '0;
      prod_reg           <= '0;
      acc                <= '0;
      for (int i = 0; i < int'(NUM_TAPS); i++) begin
        x_mem[i] <= '0;
        c_mem[i] <= (i == 0) ? UNITY : '0;
      end
    end else begin
      s_axis_in_tready   <= (state_d == ST_IDLE);
      s_axis_coef_tready <= (state_d == ST_IDLE);
      m_axis_out_tvalid  <= 1'b0;

      if (s_axis_in_tvalid && (state_q != ST_IDLE)) begin
        overflow <= 1'b1;
      end

      if (coef_fire) begin
        c_mem[coef_ptr] <= s_axis_coef_tdata;
        coef_ptr <= (s_axis_coef_tlast || (coef_ptr == LAST_IDX)) ? '0
                                                                   : coef_ptr + PTR_W'(1);
      end

      case (state_q)
        ST_IDLE: begin
          if (in_fire) begin
            x_mem[wr_ptr] <= s_axis_in_tdata;
            base          <= wr_ptr;
            wr_ptr        <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + PTR_W'(1);
            acc           <= '0;
            tap           <= '0;
          end
        end
        ST_MAC: begin
          prod_reg <= PROD_DW'(c_mem[tap]) * PROD_DW'(x_mem[rd_idx]);
          if (tap != '0) begin
            acc <= acc + ACC_DW'(prod_reg);
          end
          if (tap != LAST_IDX) begin
            tap <= tap + PTR_W'(1);
          end
        end
        ST_DRAIN: begin
          acc <= acc + ACC_DW'(prod_reg);
        end
        ST_OUT: begin
          m_axis_out_tdata  <= rs_c;
          m_axis_out_tvalid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cic_comp_fir.sv
// Scoreboard bench for cic_comp_fir: a 32-bit instance and a 16-bit instance
// (saturation), checked against a direct convolution model.
module tb_cic_comp_fir;

  localparam int NT = 5;
  localparam int LAT = NT + 2;

  typedef struct {
    longint d;
    int     cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [31:0] a_in_data;
  logic               a_in_valid, a_in_ready;
  logic signed [17:0] a_coef_data;
  logic               a_coef_valid, a_coef_last, a_coef_ready;
  logic signed [31:0] a_out_data;
  logic               a_out_valid, a_ovf;

  logic signed [15:0] b_in_data;
  logic               b_in_valid, b_in_ready;
  logic signed [17:0] b_coef_data;
  logic               b_coef_valid, b_coef_last, b_coef_ready;
  logic signed [15:0] b_out_data;
  logic               b_out_valid, b_ovf;

  cic_comp_fir #(.INP_DW(32), .OUT_DW(32), .COEF_DW(18), .NUM_TAPS(NT)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .s_axis_in_tdata(a_in_data), .s_axis_in_tvalid(a_in_valid), .s_axis_in_tready(a_in_ready),
    .s_axis_coef_tdata(a_coef_data), .s_axis_coef_tvalid(a_coef_valid),
    .s_axis_coef_tlast(a_coef_last), .s_axis_coef_tready(a_coef_ready),
    .m_axis_out_tdata(a_out_data), .m_axis_out_tvalid(a_out_valid), .overflow(a_ovf)
  );

  cic_comp_fir #(.INP_DW(16), .OUT_DW(16), .COEF_DW(18), .NUM_TAPS(NT)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .s_axis_in_tdata(b_in_data), .s_axis_in_tvalid(b_in_valid), .s_axis_in_tready(b_in_ready),
    .s_axis_coef_tdata(b_coef_data), .s_axis_coef_tvalid(b_coef_valid),
    .s_axis_coef_tlast(b_coef_last), .s_axis_coef_tready(b_coef_ready),
    .m_axis_out_tdata(b_out_data), .m_axis_out_tvalid(b_out_valid), .overflow(b_ovf)
  );

  int n_chk = 0;
  int n_bad = 0;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;

  longint mc   [2][NT];
  longint hist [2][NT];
  int     cptr [2];
  int     last_acc [2];

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < NT; k++) begin
        mc[b][k]   = (k == 0) ? 65536 : 0;
        hist[b][k] = 0;
      end
      cptr[b]     = 0;
      last_acc[b] = -100;
    end
  endtask

  // Direct convolution, round half up, saturate to the instance output width.
  function automatic longint model(input int b);
    longint acc = 0;
    longint r, hi, lo;
    int w;
    for (int k = 0; k < NT; k++) acc += mc[b][k] * hist[b][k];
    r  = (acc + 32768) >>> 16;
    w  = (b == 1) ? 16 : 32;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return r;
  endfunction

  // Drive one cycle on instance b (other instance idle) and update the model.
  task automatic step(input int b, input bit iv, input longint id,
                      input bit cv, input longint cd, input bit cl);
    int   e;
    bit   idle;
    exp_t ent;
    @(negedge clk);
    a_in_valid = 1'b0; a_in_data = '0; a_coef_valid = 1'b0; a_coef_data = '0; a_coef_last = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_coef_valid = 1'b0; b_coef_data = '0; b_coef_last = 1'b0;
    if (b == 0) begin
      a_in_valid = iv; a_in_data = 32'(id);
      a_coef_valid = cv; a_coef_data = 18'(cd); a_coef_last = cl;
    end else begin
      b_in_valid = iv; b_in_data = 16'(id);
      b_coef_valid = cv; b_coef_data = 18'(cd); b_coef_last = cl;
    end
    e    = cyc + 1;
    idle = (e >= last_acc[b] + NT + 3);
    if (cv && idle) begin
      mc[b][cptr[b]] = cd;
      cptr[b] = (cl || cptr[b] == NT - 1) ? 0 : cptr[b] + 1;
    end
    if (iv && idle) begin
      for (int k = NT - 1; k > 0; k--) hist[b][k] = hist[b][k-1];
      hist[b][0] = id;
      ent.d   = model(b);
      ent.cyc = e + LAT;
      if (b == 0) q_a.push_back(ent);
      else        q_b.push_back(ent);
      last_acc[b] = e;
    end
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(0, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic send(input int b, input longint v);
    step(b, 1'b1, v, 1'b0, 0, 1'b0);
    idle_n(9);
  endtask

  task automatic load(input int b, input longint c0, input longint c1,
                      input longint c2, input longint c3, input longint c4);
    step(b, 1'b0, 0, 1'b1, c0, 1'b0);
    step(b, 1'b0, 0, 1'b1, c1, 1'b0);
    step(b, 1'b0, 0, 1'b1, c2, 1'b0);
    step(b, 1'b0, 0, 1'b1, c3, 1'b0);
    step(b, 1'b0, 0, 1'b1, c4, 1'b1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_a_tdata"},  a_out_data, 0);
    chk({tag, "_a_tvalid"}, longint'(a_out_valid), 0);
    chk({tag, "_a_ovf"},    longint'(a_ovf), 0);
    chk({tag, "_a_irdy"},   longint'(a_in_ready), 1);
    chk({tag, "_a_crdy"},   longint'(a_coef_ready), 1);
    chk({tag, "_b_tdata"},  b_out_data, 0);
    chk({tag, "_b_ovf"},    longint'(b_ovf), 0);
    chk({tag, "_b_irdy"},   longint'(b_in_ready), 1);
  endtask

  // Output monitor: every strobe must match the head of its queue, on time.
  always @(negedge clk) begin
    if (a_out_valid) begin
      if (q_a.size() == 0) chk("a_spurious", 1, 0);
      else begin
        ea = q_a.pop_front();
        chk("a_data", a_out_data, ea.d);
        chk("a_lat", cyc, ea.cyc);
      end
    end
    if (b_out_valid) begin
      if (q_b.size() == 0) chk("b_spurious", 1, 0);
      else begin
        eb = q_b.pop_front();
        chk("b_data", b_out_data, eb.d);
        chk("b_lat", cyc, eb.cyc);
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_coef_valid = 1'b0; a_coef_data = '0; a_coef_last = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_coef_valid = 1'b0; b_coef_data = '0; b_coef_last = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_state("rst");

    // Unity pass-through after reset.
    send(0, 1000);

    // Flush, then impulse and step through an all-ones filter.
    load(0, 65536, 65536, 65536, 65536, 65536);
    for (int i = 0; i < NT; i++) send(0, 0);
    send(0, 100);
    for (int i = 0; i < NT; i++) send(0, 0);
    for (int i = 0; i < NT + 1; i++) send(0, 100);

    // Saturation on the 16-bit instance.
    load(1, 131071, 0, 0, 0, 0);
    send(1, 30000);
    send(1, -32768);
    send(1, 1000);

    // Rounding with the smallest coefficient.
    load(0, 1, 0, 0, 0, 0);
    send(0, 32768);
    send(0, -32768);
    send(0, 16384);

    // Dropped sample and ignored coefficient write while busy.
    load(0, 65536, 0, 0, 0, 0);
    step(0, 1'b1, 5, 1'b0, 0, 1'b0);
    step(0, 1'b0, 0, 1'b0, 0, 1'b0);
    chk("a_irdy_busy", longint'(a_in_ready), 0);
    step(0, 1'b0, 0, 1'b0, 0, 1'b0);
    step(0, 1'b1, 9, 1'b0, 0, 1'b0);
    step(0, 1'b0, 0, 1'b1, 3, 1'b1);
    idle_n(8);
    chk("a_ovf_set", longint'(a_ovf), 1);
    chk("b_ovf_clr", longint'(b_ovf), 0);
    send(0, 11);
    chk("a_ovf_sticky", longint'(a_ovf), 1);

    // Reset in the middle of a MAC sequence.
    load(0, 65536, 65536, 0, 0, 0);
    send(0, 55);
    step(0, 1'b1, 42, 1'b0, 0, 1'b0);
    idle_n(2);
    @(negedge clk);
    reset_n = 1'b0;
    q_a.delete();
    q_b.delete();
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_state("midrst");
    idle_n(10);
    send(0, 7);
    send(0, 0);

    for (int i = 0; i < 100 && (q_a.size() != 0 || q_b.size() != 0); i++) @(negedge clk);
    chk("drain_a", q_a.size(), 0);
    chk("drain_b", q_b.size(), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
